csr_access_ctrl: RTL and testbench

CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

---
 rtl/csr_access_ctrl.sv | 111 +++++++++++
 tb/tb_csr_access_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl.sv
// Two-requester CSR read-modify-write controller with round-robin arbitration.
// Each accepted access runs IDLE -> READ -> (WRITE) -> DONE, one access at a time.
module csr_access_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic [1:0]            core_op,
  input  logic [3:0]            core_index,
  input  logic [XLEN-1:0]       core_wdata,
  output logic                  core_ready,
  output logic                  core_done,
  output logic [XLEN-1:0]       core_rdata,
  input  logic                  dbg_req,
  input  logic [1:0]            dbg_op,
  input  logic [3:0]            dbg_index,
  input  logic [XLEN-1:0]       dbg_wdata,
  output logic                  dbg_ready,
  output logic                  dbg_done,
  output logic [XLEN-1:0]       dbg_rdata,
  input  logic [15:0][XLEN-1:0] csr_in,
  output logic                  csr_wreq,
  output logic [3:0]            csr_windex,
  output logic [XLEN-1:0]       csr_wdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t          state, state_next;
  logic [1:0]      op_q;
  logic [3:0]      idx_q;
  logic [XLEN-1:0] wdata_q, old_q, new_q;
  logic            owner_q;   // 0 = core, 1 = dbg
  logic            last_dbg;  // last grant went to dbg
  logic            grant_core, grant_dbg, accept;
  logic [XLEN-1:0] old_val, new_val;
  logic            write_en;

  always_comb begin
    grant_core = core_req & (~dbg_req | last_dbg);
    grant_dbg  = dbg_req & (~core_req | ~last_dbg);
    core_ready = (state == IDLE) & grant_core & ~rst;
    dbg_ready  = (state == IDLE) & grant_dbg & ~rst;
    accept     = core_ready | dbg_ready;
  end

  always_comb begin
    old_val = (idx_q == 4'd0) ? '0 : csr_in[idx_q];
    case (op_q)
      2'b01:   new_val = wdata_q;
      2'b10:   new_val = old_val | wdata_q;
      2'b11:   new_val = old_val & ~wdata_q;
      default: new_val = old_val;
    endcase
    write_en = (op_q != 2'b00) && (idx_q != 4'd0) && !(op_q[1] && (wdata_q == '0));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = READ;
      READ:    state_next = write_en ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_dbg   <= 1'b1;
      op_q       <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      owner_q    <= 1'b0;
      old_q      <= '0;
      new_q      <= '0;
      core_rdata <= '0;
      dbg_rdata  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q     <= dbg_ready ? dbg_op    : core_op;
        idx_q    <= dbg_ready ? dbg_index : core_index;
        wdata_q  <= dbg_ready ? dbg_wdata : core_wdata;
        owner_q  <= dbg_ready;
        last_dbg <= dbg_ready;
      end
      if (state == READ) begin
        old_q <= old_val;
        new_q <= new_val;
      end
      // rdata is loaded on entry to DONE so it is already valid during the done pulse
      if ((state == READ && !write_en) || state == WRITE) begin
        if (owner_q) dbg_rdata  <= (state == READ) ? old_val : old_q;
        else         core_rdata <= (state == READ) ? old_val : old_q;
      end
    end
  end

  always_comb begin
    csr_wreq   = (state == WRITE);
    csr_windex = idx_q;
    csr_wdata  = new_q;
    core_done  = (state == DONE) & ~owner_q;
    dbg_done   = (state == DONE) & owner_q;
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Randomized bench for csr_access_ctrl against a transaction-level model:
// arbitration winner, old/new values, write presence and done latency per access.
module tb_csr_access_ctrl;
  localparam int unsigned XLEN = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  core_req, core_ready, core_done;
  logic [1:0]            core_op;
  logic [3:0]            core_index;
  logic [XLEN-1:0]       core_wdata, core_rdata;
  logic                  dbg_req, dbg_ready, dbg_done;
  logic [1:0]            dbg_op;
  logic [3:0]            dbg_index;
  logic [XLEN-1:0]       dbg_wdata, dbg_rdata;
  logic [15:0][XLEN-1:0] mem;
  logic                  csr_wreq;
  logic [3:0]            csr_windex;
  logic [XLEN-1:0]       csr_wdata;

  logic [XLEN-1:0] mm [16];
  logic            pv [2];
  logic [1:0]      pop [2];
  logic [3:0]      pidx [2];
  logic [XLEN-1:0] pwd [2];
  logic [XLEN-1:0] exp_rd [2];
  logic            last_dbg_m;
  int              total = 0;
  int              bad = 0;

  csr_access_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_op(core_op), .core_index(core_index), .core_wdata(core_wdata),
    .core_ready(core_ready), .core_done(core_done), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_op(dbg_op), .dbg_index(dbg_index), .dbg_wdata(dbg_wdata),
    .dbg_ready(dbg_ready), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .csr_in(mem), .csr_wreq(csr_wreq), .csr_windex(csr_windex), .csr_wdata(csr_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int r, input logic req, input logic [1:0] op,
                       input logic [3:0] idx, input logic [XLEN-1:0] wd);
    if (r == 0) begin
      core_req = req; core_op = op; core_index = idx; core_wdata = wd;
    end else begin
      dbg_req = req; dbg_op = op; dbg_index = idx; dbg_wdata = wd;
    end
  endtask

  task automatic set_pending(input int r, input logic [1:0] op, input logic [3:0] idx,
                             input logic [XLEN-1:0] wd);
    pv[r] = 1'b1; pop[r] = op; pidx[r] = idx; pwd[r] = wd;
  endtask

  task automatic gen(input int r);
    set_pending(r, 2'($urandom), ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom),
                ($urandom_range(0, 3) == 0) ? '0 : XLEN'($urandom));
  endtask

  task automatic check_rdata(input string tag);
    check({tag, "_core_rdata"}, core_rdata, exp_rd[0]);
    check({tag, "_dbg_rdata"}, dbg_rdata, exp_rd[1]);
  endtask

  // One complete access: pending requests presented, winner followed to its done pulse.
  task automatic run_round();
    int              w;
    logic [XLEN-1:0] old, nv;
    logic            wr;
    @(negedge clk);
    if ($urandom_range(0, 3) == 0) begin
      int k = $urandom_range(1, 15);
      mem[k] = $urandom;
      mm[k]  = mem[k];
    end
    for (int r = 0; r < 2; r++) drive(r, pv[r], pop[r], pidx[r], pwd[r]);
    if (pv[0] && pv[1]) w = last_dbg_m ? 0 : 1;
    else                w = pv[0] ? 0 : 1;
    #1;
    check("accept_core_ready", core_ready, pv[0] && w == 0);
    check("accept_dbg_ready", dbg_ready, pv[1] && w == 1);
    check("idle_wreq", csr_wreq, 0);
    last_dbg_m = (w == 1);
    old = (pidx[w] == 0) ? '0 : mm[pidx[w]];
    case (pop[w])
      2'b01:   nv = pwd[w];
      2'b10:   nv = old | pwd[w];
      2'b11:   nv = old & ~pwd[w];
      default: nv = old;
    endcase
    wr = (pop[w] != 0) && (pidx[w] != 0) && !(pop[w] >= 2 && pwd[w] == 0);
    pv[w] = 1'b0;
    @(negedge clk);
    drive(w, 1'($urandom), 2'($urandom), 4'($urandom), XLEN'($urandom));
    #1;
    check("busy_ready", {core_ready, dbg_ready}, 0);
    check("read_wreq", csr_wreq, 0);
    check("read_done", {core_done, dbg_done}, 0);
    if (wr) begin
      @(negedge clk);
      #1;
      check("write_wreq", csr_wreq, 1);
      check("write_index", csr_windex, pidx[w]);
      check("write_data", csr_wdata, nv);
      check("write_done", {core_done, dbg_done}, 0);
      if (csr_wreq) mem[csr_windex] = csr_wdata;
      mm[pidx[w]] = nv;
    end
    @(negedge clk);
    #1;
    check("done_wreq", csr_wreq, 0);
    check("done_core", core_done, w == 0);
    check("done_dbg", dbg_done, w == 1);
    exp_rd[w] = old;
    check_rdata("done");
  endtask

  // Reset asserted while the WRITE strobe is up: access aborted, outputs back to reset values.
  task automatic reset_mid_write();
    @(negedge clk);
    pv[0] = 1'b0; pv[1] = 1'b0;
    drive(0, 1'b1, 2'b01, 4'd9, 32'hA5A5_0001);
    drive(1, 1'b0, 2'b00, 4'd0, '0);
    #1;
    check("rstw_accept", core_ready, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rstw_pre_wreq", csr_wreq, 1);
    #1 rst = 1'b1;
    #1;
    check("rstw_wreq", csr_wreq, 0);
    check("rstw_ready", {core_ready, dbg_ready}, 0);
    check("rstw_done", {core_done, dbg_done}, 0);
    exp_rd[0] = '0; exp_rd[1] = '0;
    last_dbg_m = 1'b1;
    check_rdata("rstw");
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 2'b00, 4'd0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rstw_after_done", {core_done, dbg_done}, 0);
      check("rstw_after_wreq", csr_wreq, 0);
    end
    check("rstw_mem_untouched", mem[9], mm[9]);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
    end
    mem[5] = 32'h0000_00F0;
    mem[3] = 32'h0000_000F;
    for (int i = 0; i < 16; i++) mm[i] = mem[i];
    pv[0] = 1'b0; pv[1] = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    last_dbg_m = 1'b1;
    drive(0, 1'b1, 2'b01, 4'd1, '1);
    drive(1, 1'b1, 2'b01, 4'd1, '1);
    #1;
    check("rst_ready", {core_ready, dbg_ready}, 0);
    check("rst_wreq", csr_wreq, 0);
    check("rst_done", {core_done, dbg_done}, 0);
    check_rdata("rst");
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 2'b00, 4'd0, '0);
    drive(1, 1'b0, 2'b00, 4'd0, '0);

    // tie after reset goes to core; dbg set/clear on entry 3
    set_pending(0, 2'b01, 4'd5, 32'h0000_1234);
    set_pending(1, 2'b10, 4'd3, 32'h0000_00F0);
    run_round();
    check("core_write_rdata", core_rdata, 32'h0000_00F0);
    check("core_write_mem", mem[5], 32'h0000_1234);
    run_round();
    check("dbg_set_mem", mem[3], 32'h0000_00FF);
    set_pending(1, 2'b11, 4'd3, 32'h0000_000F);
    run_round();
    check("dbg_clear_mem", mem[3], 32'h0000_00F0);
    check("dbg_clear_rdata", dbg_rdata, 32'h0000_00FF);

    // repeated ties alternate
    for (int i = 0; i < 4; i++) begin
      set_pending(0, 2'b00, 4'd5, '0);
      set_pending(1, 2'b00, 4'd3, '0);
      run_round();
      run_round();
    end

    // suppressed writes: set with zero mask, write to entry 0
    set_pending(0, 2'b10, 4'd7, '0);
    run_round();
    set_pending(0, 2'b01, 4'd0, 32'hDEAD_BEEF);
    run_round();
    check("idx0_rdata", core_rdata, 0);

    reset_mid_write();
    set_pending(0, 2'b01, 4'd9, 32'h0BAD_F00D);
    run_round();

    for (int n = 0; n < 150; n++) begin
      for (int r = 0; r < 2; r++) if (!pv[r] && $urandom_range(0, 2) != 0) gen(r);
      if (!pv[0] && !pv[1]) gen($urandom_range(0, 1));
      run_round();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
